ps2_scan_receiver: RTL

//  Parametrised PS/2 device-to-host receiver. Filters PS2_CLK, deserialises 11-bit frames, checks them, and

---
 rtl/ps2_scan_receiver.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 device-to-host scan byte receiver with FWFT output FIFO (optional PS2_BREAK_DECODE_EN)
module ps2_scan_receiver #(
    parameter int SAMPLE_DIV    = 250,
    parameter int FILTER_LEN    = 4,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DATA,
    output logic [7:0]                    CODE,
    output logic                          CODE_EXT,
    output logic                          CODE_BRK,
    output logic                          CODE_VALID,
    input  logic                          CODE_READY,
    output logic                          FRAME_ERR,
    output logic                          OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int TMR_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef PS2_BREAK_DECODE_EN
    localparam int ENTRY_W = 10;
`else
    localparam int ENTRY_W = 8;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers; both lines idle high
    // ------------------------------------------------------------------
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       ps2_clk_s;
    logic       ps2_data_s;

    // two-flop synchronisers for the asynchronous PS/2 pins
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            data_sync_q <= {data_sync_q[0], PS2_DATA};
        end
    end

    assign ps2_clk_s  = clk_sync_q[1];
    assign ps2_data_s = data_sync_q[1];

    // ------------------------------------------------------------------
    // Sample tick divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

    // free-running divider producing one tick per SAMPLE_DIV clocks
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // PS2_CLK glitch filter; falling edge is a 1->0 flip of the filtered level
    // ------------------------------------------------------------------
    logic       filt_level_q;
    logic [3:0] filt_cnt_q;
    logic       filt_flip;
    logic       fall;

    assign filt_flip = tick && (ps2_clk_s != filt_level_q) &&
                       (filt_cnt_q == 4'(FILTER_LEN - 1));
    assign fall      = filt_flip && filt_level_q;

    // count consecutive ticks disagreeing with the filtered level, flip when enough
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            filt_level_q <= 1'b1;
            filt_cnt_q   <= '0;
        end else if (tick) begin
            if (ps2_clk_s != filt_level_q) begin
                if (filt_flip) begin
                    filt_level_q <= ~filt_level_q;
                    filt_cnt_q   <= '0;
                end else begin
                    filt_cnt_q <= filt_cnt_q + 4'd1;
                end
            end else begin
                filt_cnt_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [10:0]      shift_q, shift_d;
    logic             err_d;
    logic             frame_ok;
    logic [7:0]       rx_byte;

    assign rx_byte = shift_q[8:1];

    // FSM state and frame datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            timer_q  <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            timer_q  <= timer_d;
            shift_q  <= shift_d;
        end
    end

    // next-state logic: shift on falling edges, time out idle lines, check full frames
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        timer_d  = timer_q;
        shift_d  = shift_q;
        err_d    = 1'b0;
        frame_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall && !ps2_data_s) begin
                    state_d  = S_RECV;
                    bitcnt_d = 4'd1;
                    timer_d  = '0;
                    shift_d  = {ps2_data_s, shift_q[10:1]};
                end
            end
            S_RECV: begin
                if (fall) begin
                    shift_d  = {ps2_data_s, shift_q[10:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    timer_d  = '0;
                    if (bitcnt_q == 4'd10) begin
                        state_d = S_CHECK;
                    end
                end else if (tick) begin
                    if (timer_q == TMR_W'(TIMEOUT_TICKS - 1)) begin
                        state_d = S_IDLE;
                        timer_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (!shift_q[0] && shift_q[10] && (^shift_q[9:1])) begin
                    frame_ok = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Prefix handling and push request
    // ------------------------------------------------------------------
    logic               push_req;
    logic [ENTRY_W-1:0] push_data;
    logic               push_ok;

`ifdef PS2_BREAK_DECODE_EN
    logic ext_pending_q;
    logic brk_pending_q;
    logic is_prefix;

    assign is_prefix = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
    assign push_req  = frame_ok && !is_prefix;
    assign push_data = {ext_pending_q, brk_pending_q, rx_byte};

    // latch E0/F0 prefixes; any push attempt or error consumes them
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ext_pending_q <= 1'b0;
            brk_pending_q <= 1'b0;
        end else if (err_d || push_req) begin
            ext_pending_q <= 1'b0;
            brk_pending_q <= 1'b0;
        end else if (frame_ok) begin
            if (rx_byte == 8'hE0) ext_pending_q <= 1'b1;
            if (rx_byte == 8'hF0) brk_pending_q <= 1'b1;
        end
    end
`else
    assign push_req  = frame_ok;
    assign push_data = rx_byte;
`endif

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               pop;
    logic               full;
    logic [ENTRY_W-1:0] head;

    assign CODE_VALID = (count_q != '0);
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = CODE_VALID && CODE_READY;
    assign push_ok    = push_req && (!full || pop);
    assign head       = mem[rd_ptr_q];
    assign FIFO_COUNT = count_q;
    assign CODE       = CODE_VALID ? head[7:0] : 8'h00;
`ifdef PS2_BREAK_DECODE_EN
    assign CODE_EXT   = CODE_VALID ? head[9] : 1'b0;
    assign CODE_BRK   = CODE_VALID ? head[8] : 1'b0;
`else
    assign CODE_EXT   = 1'b0;
    assign CODE_BRK   = 1'b0;
`endif

    // storage array; contents are meaningless while the FIFO is empty
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // pointers and occupancy; pointers wrap naturally on a power-of-two depth
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // registered one-cycle status pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            FRAME_ERR <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            FRAME_ERR <= err_d;
            OVERFLOW  <= push_req && !push_ok;
        end
    end

endmodule
